// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a small TX FIFO and a pollable STATUS word.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0400,
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_write,
    input  logic [31:0] data_adr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        tx,
    output logic        busy
);

    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST   = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL    = CNT_W'(FIFO_DEPTH);
    localparam logic [31:0]       STATUS_ADDR = BASE_ADDR + 32'd4;
`ifdef UART_TX_PARITY_EN
    localparam logic PARITY_FLAG = 1'b1;
`else
    localparam logic PARITY_FLAG = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t            state, state_nxt;
    logic [BAUD_W-1:0] baud_cnt, baud_nxt;
    logic [2:0]        bit_idx, bit_nxt;
    logic [7:0]        shift, shift_nxt;
    logic              tx_nxt;
    logic [7:0]        fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  count, count_nxt;
    logic              overflow, overflow_nxt;
    logic              pop_c, push_c, push_ok_c, clear_c, baud_done_c;
    logic              unused;

    assign unused = &{1'b0, write_data[31:8]};

    assign baud_done_c = (baud_cnt == BAUD_LAST);
    assign push_c      = mem_write && (data_adr == BASE_ADDR);
    assign clear_c     = mem_write && (data_adr == STATUS_ADDR) && write_data[3];
    assign push_ok_c   = push_c && ((count < CNT_FULL) || pop_c);

    // Next-state and serializer datapath
    always_comb begin
        state_nxt = state;
        tx_nxt    = tx;
        baud_nxt  = baud_cnt;
        bit_nxt   = bit_idx;
        shift_nxt = shift;
        pop_c     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (count != '0) begin
                    pop_c     = 1'b1;
                    shift_nxt = fifo_mem[rd_ptr];
                    tx_nxt    = 1'b0;
                    baud_nxt  = '0;
                    state_nxt = S_START;
                end
            end
            S_START: begin
                if (baud_done_c) begin
                    baud_nxt  = '0;
                    bit_nxt   = 3'd0;
                    tx_nxt    = shift[0];
                    state_nxt = S_DATA;
                end else begin
                    baud_nxt = baud_cnt + BAUD_W'(1);
                end
            end
            S_DATA: begin
                if (baud_done_c) begin
                    baud_nxt = '0;
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        tx_nxt    = ^shift;
                        state_nxt = S_PARITY;
`else
                        tx_nxt    = 1'b1;
                        state_nxt = S_STOP;
`endif
                    end else begin
                        bit_nxt = bit_idx + 3'd1;
                        tx_nxt  = shift[bit_nxt];
                    end
                end else begin
                    baud_nxt = baud_cnt + BAUD_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_done_c) begin
                    baud_nxt  = '0;
                    tx_nxt    = 1'b1;
                    state_nxt = S_STOP;
                end else begin
                    baud_nxt = baud_cnt + BAUD_W'(1);
                end
            end
`endif
            S_STOP: begin
                if (baud_done_c) begin
                    baud_nxt = '0;
                    // Chain straight into the next start bit so queued frames leave no gap
                    if (count != '0) begin
                        pop_c     = 1'b1;
                        shift_nxt = fifo_mem[rd_ptr];
                        tx_nxt    = 1'b0;
                        state_nxt = S_START;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end else begin
                    baud_nxt = baud_cnt + BAUD_W'(1);
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // FIFO occupancy and sticky overflow; a drop sets it even if a clear arrives
    always_comb begin
        unique case ({push_ok_c, pop_c})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
        overflow_nxt = overflow;
        if (push_c && !push_ok_c) begin
            overflow_nxt = 1'b1;
        end else if (clear_c) begin
            overflow_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            tx       <= 1'b1;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            tx       <= tx_nxt;
            baud_cnt <= baud_nxt;
            bit_idx  <= bit_nxt;
            shift    <= shift_nxt;
            count    <= count_nxt;
            overflow <= overflow_nxt;
            busy     <= (state_nxt != S_IDLE) || (count_nxt != '0);
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push_ok_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok_c) begin
            fifo_mem[wr_ptr] <= write_data[7:0];
        end
    end

    always_comb begin
        read_data = '0;
        if (data_adr == STATUS_ADDR) begin
            read_data[0]   = (count == CNT_FULL);
            read_data[1]   = (count == '0);
            read_data[2]   = (state != S_IDLE);
            read_data[3]   = overflow;
            read_data[8:4] = 5'(count);
            read_data[9]   = PARITY_FLAG;
        end
    end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter on the processor top's data-memory write port (mem_write, data_adr, write_data).
- Drives the serial pin that the top exports as `salida`.
- Software stores bytes to a DATA register. Bytes queue in a small FIFO and are serialized 8N1, LSB first, at a fixed baud divisor.
- A STATUS register is readable for polling.

Parameters:
- BASE_ADDR, 32'h0000_0400: word address of the DATA register. STATUS sits at BASE_ADDR+4.
- CLKS_PER_BIT, 868: clk cycles per serial bit (100 MHz / 115200). Legal range 2..65535.
- FIFO_DEPTH, 4: transmit FIFO entries. Must be a power of 2, range 2..16.

Ports:
- clk, in, 1: system clock; all state updates on the rising edge.
- reset, in, 1: synchronous, active-high; sampled on the rising edge of clk.
- mem_write, in, 1: store strobe from the core.
- data_adr, in, 32: store/load address from the core.
- write_data, in, 32: store data from the core.
- read_data, out, 32: STATUS value, combinational from data_adr; 0 when the address misses.
- tx, out, 1: serial line, registered, idles high.
- busy, out, 1: high while a frame is on the line or the FIFO is non-empty.

Behaviour:
- Reset: tx=1, FIFO emptied (count=0), FSM=IDLE, bit/baud counters=0, overflow flag=0, busy=0.
- Reset mid-frame aborts at that edge. tx=1 from the next cycle; queued bytes are discarded.
- DATA write: mem_write=1 and data_adr==BASE_ADDR pushes write_data[7:0]. Upper bits are ignored.
- Push rule: the push is accepted if count<FIFO_DEPTH, or if a pop occurs in the same cycle.
  - If the FIFO is full and there is no same-cycle pop, the byte is dropped and the sticky overflow flag is set.
- STATUS write: mem_write=1 and data_adr==BASE_ADDR+4 with write_data[3]=1 clears overflow. Set wins over clear in the same cycle.
- STATUS read: read_data fields, all other bits 0:
  - [0] full
  - [1] empty
  - [2] line active (FSM≠IDLE)
  - [3] overflow
  - [8:4] count
- Writes to any other address are ignored.
- FSM states: IDLE, START, DATA, STOP (plus PARITY under the optional feature).
- IDLE, FIFO non-empty: next edge pops the head into the shift register, tx<=0, state→START, baud counter=0.
  - Write latency: a byte written at edge k into an empty FIFO in IDLE gives tx low after edge k+1.
- START: hold tx=0 for CLKS_PER_BIT cycles, then tx<=shift[0], state→DATA, bit index=0.
- DATA: each bit is held CLKS_PER_BIT cycles, LSB first. After bit 7 expires: tx<=1, state→STOP.
- STOP: hold tx=1 for CLKS_PER_BIT cycles. On expiry:
  - FIFO non-empty: pop and go directly to START (tx<=0), with no idle gap between back-to-back frames.
  - Otherwise: go to IDLE.
- Frame length: exactly 10·CLKS_PER_BIT cycles (11·CLKS_PER_BIT with parity).
- Baud counter: width is clog2(CLKS_PER_BIT). It wraps at CLKS_PER_BIT-1 and never free-runs in IDLE.
- FIFO pointers wrap modulo FIFO_DEPTH. Count is tracked separately, so full and empty are unambiguous.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - After bit 7, state PARITY drives the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles, then STOP.
  - STATUS[9] reads 1 to flag parity support.
- Undefined:
  - No PARITY state; DATA goes straight to STOP.
  - STATUS[9] reads 0.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4, BASE_ADDR=32'h400):
- Reset held 5 cycles, then released -> tx=1, busy=0, read_data at 0x404 = 32'h0000_0002.
- Store 32'hFFFF_FF55 to 0x400 at edge k:
  - tx low for cycles k+1..k+4.
  - Then bits 1,0,1,0,1,0,1,0, 4 cycles each.
  - Then stop high for 4 cycles.
  - busy=0 at cycle k+41.
- Store 0xA1,0xB2,0xC3,0xD4,0xE5 on consecutive cycles while IDLE:
  - The first is popped immediately; the rest fill the FIFO to count=4.
  - All 5 bytes are serialized back-to-back with no gap (200 cycles).
  - STATUS[3]=0.
- With the line busy and the FIFO full, store 0x77:
  - Byte is dropped and STATUS[3]=1.
  - Store 32'h8 to 0x404 -> STATUS[3]=0.
  - 0x77 never appears on tx.
- Assert reset at bit 3 of a frame with 2 bytes queued:
  - tx=1 the cycle after the reset edge; count=0.
  - No further start bit after reset is released.
- UART_TX_PARITY_EN defined, store 0x07 -> parity bit=1 after bit 7; frame is 44 cycles; STATUS[9]=1.
